// File: rtl/pacman_motion_ctrl.sv
// Pac-Man motion controller: advances the sprite once per frame tick. Before
// each move it asks the maze wall lookup, over a req/ack handshake, whether the
// candidate position is free. A turn request from the buttons is buffered until
// it can be taken.
module pacman_motion_ctrl #(
    parameter int STEP        = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 610,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 450,
    parameter int START_X     = 304,
    parameter int START_Y     = 224,
    parameter int WRAP_X      = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [3:0] btn,
    output logic       wall_req,
    output logic [9:0] wall_qx,
    output logic [9:0] wall_qy,
    input  logic       wall_ack,
    input  logic       wall_hit,
    output logic [9:0] pm_xpos,
    output logic [9:0] pm_ypos,
    output logic [3:0] pm_direction,
    output logic       moving,
    output logic       missed_tick
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, TRY_NEW, TRY_CUR, UPDATE} state_t;

    typedef struct packed {
        logic       ok;
        logic [9:0] x;
        logic [9:0] y;
    } cand_t;

    state_t      state, state_n;
    logic [3:0]  pending, pend_n, dir_n, upd_dir, upd_dir_n, issue_dir;
    logic [9:0]  x_n, y_n, qx_n, qy_n, upd_x, upd_y, upd_x_n, upd_y_n;
    logic        req_n, moving_n, missed_n, issued, issued_n;
    logic        do_issue, q_done, q_clear;
    logic [TW-1:0] timer, timer_n;
    cand_t       cand_pend, cand_cur, issue_c;

    // Position one STEP along d; out-of-range y (or x without tunnel) is blocked,
    // while with the tunnel an x overrun reappears on the opposite edge.
    function automatic cand_t next_pos(input logic [3:0] d, input logic [9:0] x,
                                       input logic [9:0] y);
        cand_t c;
        int    nx;
        int    ny;
        nx = int'(x);
        ny = int'(y);
        if (d[3])      ny = ny - STEP;
        else if (d[2]) ny = ny + STEP;
        else if (d[1]) nx = nx - STEP;
        else if (d[0]) nx = nx + STEP;
        c.ok = 1'b1;
        if (ny < Y_MIN || ny > Y_MAX) c.ok = 1'b0;
        if (nx < X_MIN) begin
            if (WRAP_X != 0) nx = X_MAX;
            else             c.ok = 1'b0;
        end else if (nx > X_MAX) begin
            if (WRAP_X != 0) nx = X_MIN;
            else             c.ok = 1'b0;
        end
        c.x = nx[9:0];
        c.y = ny[9:0];
        return c;
    endfunction

    // Heading reversal: up<->down, left<->right.
    function automatic logic [3:0] opposite(input logic [3:0] d);
        return {d[2], d[3], d[0], d[1]};
    endfunction

    assign cand_pend = next_pos(pending, pm_xpos, pm_ypos);
    assign cand_cur  = next_pos(pm_direction, pm_xpos, pm_ypos);

    // Next-state logic: tick dispatch, wall queries with timeout, move commit and
    // the always-on button buffer (a fresh one-hot press wins over clearing).
    always_comb begin
        state_n   = state;
        x_n       = pm_xpos;
        y_n       = pm_ypos;
        dir_n     = pm_direction;
        pend_n    = pending;
        moving_n  = moving;
        req_n     = wall_req;
        qx_n      = wall_qx;
        qy_n      = wall_qy;
        timer_n   = timer;
        issued_n  = issued;
        upd_x_n   = upd_x;
        upd_y_n   = upd_y;
        upd_dir_n = upd_dir;
        missed_n  = frame_tick && (state != IDLE);
        do_issue  = 1'b0;
        issue_dir = pm_direction;
        issue_c   = cand_cur;
        q_done    = wall_req && (wall_ack || (timer == TW'(ACK_TIMEOUT - 1)));
        q_clear   = wall_req && wall_ack && !wall_hit;
        if (wall_req && !q_done) timer_n = timer + 1'b1;

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    if (pending != 4'b0 && pending == opposite(pm_direction)) begin
                        if (cand_pend.ok) begin
                            state_n   = UPDATE;
                            upd_x_n   = cand_pend.x;
                            upd_y_n   = cand_pend.y;
                            upd_dir_n = pending;
                        end else begin
                            moving_n = 1'b0;
                        end
                    end else if (pending != 4'b0) begin
                        state_n   = TRY_NEW;
                        do_issue  = 1'b1;
                        issue_dir = pending;
                        issue_c   = cand_pend;
                    end else begin
                        state_n  = TRY_CUR;
                        do_issue = 1'b1;
                    end
                end
            end
            TRY_NEW: begin
                if (!wall_req) begin
                    state_n  = TRY_CUR;
                    issued_n = 1'b0;
                end else if (q_done) begin
                    req_n = 1'b0;
                    if (q_clear) begin
                        state_n = UPDATE;
                    end else begin
                        state_n  = TRY_CUR;
                        issued_n = 1'b0;
                    end
                end
            end
            TRY_CUR: begin
                if (!issued) begin
                    do_issue = 1'b1;
                end else if (!wall_req) begin
                    state_n  = IDLE;
                    moving_n = 1'b0;
                end else if (q_done) begin
                    req_n = 1'b0;
                    if (q_clear) begin
                        state_n = UPDATE;
                    end else begin
                        state_n  = IDLE;
                        moving_n = 1'b0;
                    end
                end
            end
            UPDATE: begin
                x_n      = upd_x;
                y_n      = upd_y;
                dir_n    = upd_dir;
                moving_n = 1'b1;
                if (upd_dir == pending) pend_n = 4'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (do_issue) begin
            req_n     = issue_c.ok;
            timer_n   = '0;
            issued_n  = 1'b1;
            upd_x_n   = issue_c.x;
            upd_y_n   = issue_c.y;
            upd_dir_n = issue_dir;
            if (issue_c.ok) begin
                qx_n = issue_c.x;
                qy_n = issue_c.y;
            end
        end

        if ($onehot(btn)) pend_n = btn;
    end

    // State register; reset also swallows a frame_tick in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pm_xpos      <= 10'(START_X);
            pm_ypos      <= 10'(START_Y);
            pm_direction <= 4'b0010;
            pending      <= 4'b0;
            moving       <= 1'b0;
            wall_req     <= 1'b0;
            wall_qx      <= 10'd0;
            wall_qy      <= 10'd0;
            missed_tick  <= 1'b0;
            timer        <= '0;
            issued       <= 1'b0;
            upd_x        <= 10'd0;
            upd_y        <= 10'd0;
            upd_dir      <= 4'b0;
        end else begin
            state        <= state_n;
            pm_xpos      <= x_n;
            pm_ypos      <= y_n;
            pm_direction <= dir_n;
            pending      <= pend_n;
            moving       <= moving_n;
            wall_req     <= req_n;
            wall_qx      <= qx_n;
            wall_qy      <= qy_n;
            missed_tick  <= missed_n;
            timer        <= timer_n;
            issued       <= issued_n;
            upd_x        <= upd_x_n;
            upd_y        <= upd_y_n;
            upd_dir      <= upd_dir_n;
        end
    end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Bench for pacman_motion_ctrl: a table of tick-level vectors, hand-written
// latency/wrap/timeout/reset sequences, and a randomized run against a
// transaction-level model of the movement rules.
module tb_pacman_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst, frame_tick;
    logic [3:0] btn;
    logic       wall_req, wall_ack, wall_hit, moving, missed_tick;
    logic [9:0] wall_qx, wall_qy, pm_xpos, pm_ypos;
    logic [3:0] pm_direction;

    logic       wall_req_nw, ack_nw, hit_nw, moving_nw, missed_nw;
    logic [9:0] qx_nw, qy_nw, x_nw, y_nw;
    logic [3:0] dir_nw;

    int  tests = 0;
    int  fails = 0;
    bit  use_maze = 0, no_ack = 0, rand_delay = 0;
    bit  hit_script[$];
    int  qlog_x[$], qlog_y[$], exq_x[$], exq_y[$];
    int  nw_queries = 0;
    int  m_x, m_y;
    logic [3:0] m_dir, m_pend;
    logic m_mov;
    int  req_tr[60], qx_tr[60], qy_tr[60];

    typedef struct {
        logic [3:0] b;
        logic [1:0] hits;
        int         ex;
        int         ey;
        logic [3:0] edir;
        logic       emov;
        int         enq;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    pacman_motion_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn),
        .wall_req(wall_req), .wall_qx(wall_qx), .wall_qy(wall_qy),
        .wall_ack(wall_ack), .wall_hit(wall_hit),
        .pm_xpos(pm_xpos), .pm_ypos(pm_ypos), .pm_direction(pm_direction),
        .moving(moving), .missed_tick(missed_tick)
    );

    pacman_motion_ctrl #(.WRAP_X(0)) dut_nw (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn(btn),
        .wall_req(wall_req_nw), .wall_qx(qx_nw), .wall_qy(qy_nw),
        .wall_ack(ack_nw), .wall_hit(hit_nw),
        .pm_xpos(x_nw), .pm_ypos(y_nw), .pm_direction(dir_nw),
        .moving(moving_nw), .missed_tick(missed_nw)
    );

    function automatic bit is_wall(input int x, input int y);
        return (((x * 7 + y * 13) / 2) % 9) == 0;
    endfunction

    // Spec movement rule: one STEP along d, y edges are walls, x tunnels.
    function automatic bit mcand(input logic [3:0] d, input int x, input int y,
                                 output int nx, output int ny);
        int dx, dy;
        dx = 0;
        dy = 0;
        case (d)
            4'b1000: dy = -2;
            4'b0100: dy = 2;
            4'b0010: dx = -2;
            4'b0001: dx = 2;
            default: ;
        endcase
        nx = x + dx;
        ny = y + dy;
        if (ny < 0 || ny > 450) return 1'b0;
        if (nx < 0) nx = 610;
        else if (nx > 610) nx = 0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] reverse_of(input logic [3:0] d);
        case (d)
            4'b1000: return 4'b0100;
            4'b0100: return 4'b1000;
            4'b0010: return 4'b0001;
            4'b0001: return 4'b0010;
            default: return 4'b0000;
        endcase
    endfunction

    // Wall lookup responder for the main instance: logs each query, answers
    // after an optional random delay, or never when no_ack is set.
    initial begin
        bit seen;
        int cnt;
        bit h;
        seen = 0;
        cnt = 0;
        wall_ack = 0;
        wall_hit = 0;
        forever begin
            @(negedge clk);
            wall_ack = 0;
            wall_hit = 0;
            if (!wall_req) begin
                seen = 0;
            end else begin
                if (!seen) begin
                    seen = 1;
                    qlog_x.push_back(int'(wall_qx));
                    qlog_y.push_back(int'(wall_qy));
                    cnt = rand_delay ? int'($urandom_range(0, 3)) : 0;
                end
                if (!no_ack) begin
                    if (cnt == 0) begin
                        if (hit_script.size() > 0) h = hit_script.pop_front();
                        else if (use_maze)         h = is_wall(int'(wall_qx), int'(wall_qy));
                        else                       h = 0;
                        wall_ack = 1;
                        wall_hit = h;
                        seen = 0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Responder for the no-tunnel instance: every query is free.
    initial begin
        ack_nw = 0;
        hit_nw = 0;
        forever begin
            @(negedge clk);
            if (wall_req_nw && !ack_nw) begin
                ack_nw = 1;
                nw_queries++;
            end else begin
                ack_nw = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1;
        frame_tick = 0;
        btn = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        hit_script.delete();
        qlog_x.delete();
        qlog_y.delete();
    endtask

    task automatic applyStimulus(input logic [3:0] b);
        qlog_x.delete();
        qlog_y.delete();
        if (b != 4'b0) begin
            btn = b;
            @(negedge clk);
            btn = 0;
        end
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        repeat (20) @(negedge clk);
    endtask

    task automatic modelTick();
        int  cx, cy;
        bit  done;
        logic [3:0] d;
        exq_x.delete();
        exq_y.delete();
        done = 0;
        if (m_pend != 0 && m_pend == reverse_of(m_dir)) begin
            done = 1;
            if (mcand(m_pend, m_x, m_y, cx, cy)) begin
                d = m_pend; m_x = cx; m_y = cy; m_dir = d; m_mov = 1; m_pend = 0;
            end else begin
                m_mov = 0;
            end
        end
        if (!done && m_pend != 0 && mcand(m_pend, m_x, m_y, cx, cy)) begin
            exq_x.push_back(cx);
            exq_y.push_back(cy);
            if (!is_wall(cx, cy)) begin
                d = m_pend; m_x = cx; m_y = cy; m_dir = d; m_mov = 1; m_pend = 0;
                done = 1;
            end
        end
        if (!done) begin
            if (mcand(m_dir, m_x, m_y, cx, cy)) begin
                exq_x.push_back(cx);
                exq_y.push_back(cy);
                if (!is_wall(cx, cy)) begin
                    m_x = cx; m_y = cy; m_mov = 1;
                    done = 1;
                end
            end
            if (!done) m_mov = 0;
        end
    endtask

    initial begin
        int  len1, len2, rise, missed_cnt, k;
        logic [3:0] b;

        vecs[0] = '{4'b0000, 2'b00, 302, 224, 4'b0010, 1'b1, 1};
        vecs[1] = '{4'b0000, 2'b00, 300, 224, 4'b0010, 1'b1, 1};
        vecs[2] = '{4'b0000, 2'b00, 298, 224, 4'b0010, 1'b1, 1};
        vecs[3] = '{4'b0001, 2'b00, 300, 224, 4'b0001, 1'b1, 0};
        vecs[4] = '{4'b1000, 2'b01, 302, 224, 4'b0001, 1'b1, 2};
        vecs[5] = '{4'b0000, 2'b00, 302, 222, 4'b1000, 1'b1, 1};
        vecs[6] = '{4'b1100, 2'b00, 302, 220, 4'b1000, 1'b1, 1};

        doReset();
        checkOutput("reset xpos", pm_xpos, 304);
        checkOutput("reset ypos", pm_ypos, 224);
        checkOutput("reset dir", pm_direction, 2);
        checkOutput("reset moving", moving, 0);
        checkOutput("reset wall_req", wall_req, 0);
        checkOutput("reset wall_qx", wall_qx, 0);
        checkOutput("reset wall_qy", wall_qy, 0);
        checkOutput("reset missed", missed_tick, 0);

        for (int i = 0; i < 7; i++) begin
            hit_script.delete();
            hit_script.push_back(vecs[i].hits[0]);
            hit_script.push_back(vecs[i].hits[1]);
            applyStimulus(vecs[i].b);
            checkOutput($sformatf("v%0d xpos", i), pm_xpos, vecs[i].ex);
            checkOutput($sformatf("v%0d ypos", i), pm_ypos, vecs[i].ey);
            checkOutput($sformatf("v%0d dir", i), pm_direction, vecs[i].edir);
            checkOutput($sformatf("v%0d moving", i), moving, vecs[i].emov);
            checkOutput($sformatf("v%0d queries", i), qlog_x.size(), vecs[i].enq);
        end
        checkOutput("v4 second query x", (qlog_x.size() > 0) ? 1 : 0, 1);

        // Latency after an accepting ack, then after a reversal.
        doReset();
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            if (wall_ack) break;
            k++;
        end
        checkOutput("ack seen", (k < 20) ? 1 : 0, 1);
        #1;
        checkOutput("lat ack+1 xpos", pm_xpos, 304);
        @(posedge clk);
        #1;
        checkOutput("lat ack+2 xpos", pm_xpos, 302);
        @(negedge clk);
        btn = 4'b0001;
        @(negedge clk);
        btn = 0;
        qlog_x.delete();
        frame_tick = 1;
        @(posedge clk);
        #1;
        frame_tick = 0;
        checkOutput("rev tick+1 xpos", pm_xpos, 302);
        @(posedge clk);
        #1;
        checkOutput("rev tick+2 xpos", pm_xpos, 304);
        checkOutput("rev dir", pm_direction, 1);
        repeat (3) @(negedge clk);
        checkOutput("rev queries", qlog_x.size(), 0);

        // Tunnel wrap at the left edge, and the no-tunnel variant stopping there.
        doReset();
        repeat (152) applyStimulus(4'b0000);
        checkOutput("wrap pre xpos", pm_xpos, 0);
        checkOutput("nowrap pre xpos", x_nw, 0);
        nw_queries = 0;
        applyStimulus(4'b0000);
        checkOutput("wrap qx", (qlog_x.size() > 0) ? qlog_x[0] : -1, 610);
        checkOutput("wrap xpos", pm_xpos, 610);
        checkOutput("wrap moving", moving, 1);
        checkOutput("nowrap xpos", x_nw, 0);
        checkOutput("nowrap moving", moving_nw, 0);
        checkOutput("nowrap queries", nw_queries, 0);

        // Unanswered queries: both time out, and a tick during the wait is missed.
        doReset();
        no_ack = 1;
        btn = 4'b1000;
        @(negedge clk);
        btn = 0;
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        missed_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            req_tr[i] = int'(wall_req);
            qx_tr[i] = int'(wall_qx);
            qy_tr[i] = int'(wall_qy);
            if (missed_tick) missed_cnt++;
            frame_tick = (i == 5);
            @(negedge clk);
        end
        frame_tick = 0;
        len1 = 0;
        while (len1 < 60 && req_tr[len1] == 1) len1++;
        rise = len1;
        while (rise < 60 && req_tr[rise] == 0) rise++;
        len2 = 0;
        while (rise + len2 < 60 && req_tr[rise + len2] == 1) len2++;
        checkOutput("timeout first req length", len1, 15);
        checkOutput("timeout second req length", len2, 15);
        checkOutput("timeout cur qx", (rise < 60) ? qx_tr[rise] : -1, 302);
        checkOutput("timeout cur qy", (rise < 60) ? qy_tr[rise] : -1, 224);
        checkOutput("missed_tick pulses", missed_cnt, 1);
        checkOutput("timeout xpos", pm_xpos, 304);
        checkOutput("timeout ypos", pm_ypos, 224);
        checkOutput("timeout moving", moving, 0);

        // Reset in the middle of a query, with a tick and a two-button press.
        doReset();
        btn = 4'b1000;
        @(negedge clk);
        btn = 0;
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        repeat (3) @(negedge clk);
        checkOutput("midq wall_req before rst", wall_req, 1);
        rst = 1;
        frame_tick = 1;
        btn = 4'b1100;
        @(negedge clk);
        checkOutput("midq wall_req", wall_req, 0);
        checkOutput("midq xpos", pm_xpos, 304);
        checkOutput("midq ypos", pm_ypos, 224);
        checkOutput("midq dir", pm_direction, 2);
        checkOutput("midq moving", moving, 0);
        rst = 0;
        frame_tick = 0;
        @(negedge clk);
        btn = 0;
        no_ack = 0;
        repeat (2) @(negedge clk);
        checkOutput("midq tick ignored", wall_req, 0);
        applyStimulus(4'b0000);
        checkOutput("post rst xpos", pm_xpos, 302);
        checkOutput("post rst ypos", pm_ypos, 224);
        checkOutput("post rst dir", pm_direction, 2);

        // Randomized buttons and maze walls against the transaction model.
        doReset();
        use_maze = 1;
        rand_delay = 1;
        m_x = 304; m_y = 224; m_dir = 4'b0010; m_pend = 4'b0; m_mov = 0;
        for (int it = 0; it < 60; it++) begin
            b = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
            if ($countones(b) == 1) m_pend = b;
            applyStimulus(b);
            modelTick();
            checkOutput($sformatf("rand%0d xpos", it), pm_xpos, m_x);
            checkOutput($sformatf("rand%0d ypos", it), pm_ypos, m_y);
            checkOutput($sformatf("rand%0d dir", it), pm_direction, m_dir);
            checkOutput($sformatf("rand%0d moving", it), moving, m_mov);
            checkOutput($sformatf("rand%0d queries", it), qlog_x.size(), exq_x.size());
            for (int q = 0; q < exq_x.size() && q < qlog_x.size(); q++) begin
                checkOutput($sformatf("rand%0d q%0d x", it, q), qlog_x[q], exq_x[q]);
                checkOutput($sformatf("rand%0d q%0d y", it, q), qlog_y[q], exq_y[q]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
